// File: rtl/sii_ncu_xfer_sched.sv
// ---------------------------------------------------------------------------
// sii_ncu_xfer_sched
//   SII-side scheduler for the inbound SII->NCU path. Two requesters share the
//   path: PIO completion (side 0) and Mondo interrupt (side 1), picked
//   round-robin. A packet is sent as req/gnt, one header beat, then PAY_BEATS
//   payload beats, each beat with two even-parity bits.
//
//   Optional feature: define SII_NCU_PERR_INJ_EN to add the perr_inj input,
//   which corrupts dparity[0] of the first payload beat of the next packet
//   latched while it is high.
//
// Ports
//   iol2clk          clock, all logic on posedge
//   rst              synchronous active-high reset
//   pio_vld/hdr/pay  PIO completion packet (held until pio_ack)
//   pio_ack          1-cycle pulse on the last PIO payload beat
//   mon_vld/hdr/pay  Mondo packet (held until mon_ack)
//   mon_ack          1-cycle pulse on the last Mondo payload beat
//   sii_ncu_req      transfer request, held until ncu_sii_gnt
//   ncu_sii_gnt      grant pulse from NCU
//   sii_ncu_data     header/payload beat, 0 when not transferring
//   sii_ncu_dparity  [0]=^data[15:0], [1]=^data[31:16]
//   gnt_tmo_err      sticky: no grant within GNT_TMO cycles of requesting
//   spur_gnt_err     sticky: grant seen while not requesting
//   perr_inj         (SII_NCU_PERR_INJ_EN only) parity error injection arm
// ---------------------------------------------------------------------------
module sii_ncu_xfer_sched #(
  parameter int DATA_W    = 32,
  parameter int PAY_BEATS = 4,
  parameter int GNT_TMO   = 255
) (
  input  logic                          iol2clk,
  input  logic                          rst,
  input  logic                          pio_vld,
  input  logic [DATA_W-1:0]             pio_hdr,
  input  logic [DATA_W*PAY_BEATS-1:0]   pio_pay,
  output logic                          pio_ack,
  input  logic                          mon_vld,
  input  logic [DATA_W-1:0]             mon_hdr,
  input  logic [DATA_W*PAY_BEATS-1:0]   mon_pay,
  output logic                          mon_ack,
  output logic                          sii_ncu_req,
  input  logic                          ncu_sii_gnt,
  output logic [DATA_W-1:0]             sii_ncu_data,
  output logic [DATA_W/16-1:0]          sii_ncu_dparity,
  output logic                          gnt_tmo_err,
  output logic                          spur_gnt_err
`ifdef SII_NCU_PERR_INJ_EN
  , input  logic                        perr_inj
`endif
);

  localparam int CNT_W = (PAY_BEATS > 1) ? $clog2(PAY_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PAY_BEATS - 1);
  localparam logic [7:0] TMO_LIM = 8'(GNT_TMO);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HDR  = 2'd2,
    ST_PAY  = 2'd3
  } state_t;

  // Even parity over each 16-bit half of a beat.
  function automatic logic [1:0] beat_parity(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  state_t            state_r, state_nxt;
  logic              sel_r, sel_nxt;          // 0 = PIO, 1 = Mondo
  logic              rr_ptr_r, rr_nxt;        // last completed winner
  logic              won_r, won_nxt;          // a packet completed since reset
  logic              arm_r, arm_nxt;          // parity injection pending
  logic [CNT_W-1:0]  beat_cnt_r, beat_nxt;
  logic [7:0]        tmo_cnt_r, tmo_nxt;
  logic [7:0]        tmo_inc_s;
  logic [DATA_W-1:0] hdr_r;
  logic [DATA_W-1:0] pay_r [PAY_BEATS];

  logic              req_r, req_nxt;
  logic [DATA_W-1:0] data_r, data_nxt;
  logic [1:0]        par_r, par_nxt;
  logic              pio_ack_r, pio_ack_nxt;
  logic              mon_ack_r, mon_ack_nxt;
  logic              tmo_err_r, tmo_err_nxt;
  logic              spur_err_r, spur_err_nxt;

  logic              latch_s;
  logic              win_s;
  logic              ack_s;
  logic              par_inv_s;
  logic              inj_s;

  assign sii_ncu_req     = req_r;
  assign sii_ncu_data    = data_r;
  assign sii_ncu_dparity = par_r;
  assign pio_ack         = pio_ack_r;
  assign mon_ack         = mon_ack_r;
  assign gnt_tmo_err     = tmo_err_r;
  assign spur_gnt_err    = spur_err_r;

`ifdef SII_NCU_PERR_INJ_EN
  assign inj_s = perr_inj;
`else
  assign inj_s = 1'b0;
`endif

  // Saturating increment of the grant wait counter.
  assign tmo_inc_s = (tmo_cnt_r == 8'hFF) ? tmo_cnt_r : (tmo_cnt_r + 8'd1);

  // Round-robin pick: a tie goes to PIO until a packet has completed,
  // afterwards to the side that did not win last.
  always_comb begin
    win_s = 1'b0;
    if (pio_vld && mon_vld) begin
      win_s = won_r ? ~rr_ptr_r : 1'b0;
    end else if (mon_vld) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_nxt    = state_r;
    latch_s      = 1'b0;
    sel_nxt      = sel_r;
    rr_nxt       = rr_ptr_r;
    won_nxt      = won_r;
    arm_nxt      = arm_r;
    beat_nxt     = beat_cnt_r;
    tmo_nxt      = tmo_cnt_r;
    tmo_err_nxt  = tmo_err_r;
    spur_err_nxt = spur_err_r | (ncu_sii_gnt && (state_r != ST_REQ));
    req_nxt      = 1'b0;
    data_nxt     = '0;
    par_inv_s    = 1'b0;
    ack_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (pio_vld || mon_vld) begin
          latch_s   = 1'b1;
          sel_nxt   = win_s;
          arm_nxt   = inj_s;
          tmo_nxt   = 8'd0;
          req_nxt   = 1'b1;
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ncu_sii_gnt) begin
          tmo_nxt   = 8'd0;
          data_nxt  = hdr_r;
          state_nxt = ST_HDR;
        end else begin
          req_nxt = 1'b1;
          tmo_nxt = tmo_inc_s;
          if (tmo_inc_s >= TMO_LIM) begin
            tmo_err_nxt = 1'b1;
          end else begin
            tmo_err_nxt = tmo_err_r;
          end
        end
      end
      ST_HDR: begin
        // First payload beat goes out next; it is also the last when PAY_BEATS=1.
        data_nxt  = pay_r[0];
        par_inv_s = arm_r;
        arm_nxt   = 1'b0;
        beat_nxt  = '0;
        state_nxt = ST_PAY;
        if (LAST_BEAT == '0) begin
          ack_s = 1'b1;
        end else begin
          ack_s = 1'b0;
        end
      end
      ST_PAY: begin
        // beat_cnt_r is the beat currently on the bus; load the following one.
        if (beat_cnt_r == LAST_BEAT) begin
          rr_nxt    = sel_r;
          won_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          beat_nxt = beat_cnt_r + CNT_W'(1);
          data_nxt = pay_r[beat_nxt];
          if (beat_nxt == LAST_BEAT) begin
            ack_s = 1'b1;
          end else begin
            ack_s = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    par_nxt     = beat_parity(data_nxt) ^ {1'b0, par_inv_s};
    pio_ack_nxt = ack_s & ~sel_nxt;
    mon_ack_nxt = ack_s & sel_nxt;
  end

  // State, control and registered output update.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sel_r      <= 1'b0;
      rr_ptr_r   <= 1'b0;
      won_r      <= 1'b0;
      arm_r      <= 1'b0;
      beat_cnt_r <= '0;
      tmo_cnt_r  <= 8'd0;
      req_r      <= 1'b0;
      data_r     <= '0;
      par_r      <= 2'b00;
      pio_ack_r  <= 1'b0;
      mon_ack_r  <= 1'b0;
      tmo_err_r  <= 1'b0;
      spur_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      sel_r      <= sel_nxt;
      rr_ptr_r   <= rr_nxt;
      won_r      <= won_nxt;
      arm_r      <= arm_nxt;
      beat_cnt_r <= beat_nxt;
      tmo_cnt_r  <= tmo_nxt;
      req_r      <= req_nxt;
      data_r     <= data_nxt;
      par_r      <= par_nxt;
      pio_ack_r  <= pio_ack_nxt;
      mon_ack_r  <= mon_ack_nxt;
      tmo_err_r  <= tmo_err_nxt;
      spur_err_r <= spur_err_nxt;
    end
  end

  // Holding registers for the winning packet, captured when it is picked.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      hdr_r <= '0;
      for (int k = 0; k < PAY_BEATS; k++) begin
        pay_r[k] <= '0;
      end
    end else if (latch_s) begin
      hdr_r <= win_s ? mon_hdr : pio_hdr;
      for (int k = 0; k < PAY_BEATS; k++) begin
        pay_r[k] <= win_s ? mon_pay[k*DATA_W +: DATA_W] : pio_pay[k*DATA_W +: DATA_W];
      end
    end else begin
      hdr_r <= hdr_r;
      for (int k = 0; k < PAY_BEATS; k++) begin
        pay_r[k] <= pay_r[k];
      end
    end
  end

endmodule

// File: tb/tb_sii_ncu_xfer_sched.sv
module tb_sii_ncu_xfer_sched;

  localparam int PB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pio_vld, mon_vld, ncu_sii_gnt;
  logic [31:0]     pio_hdr, mon_hdr;
  logic [32*PB-1:0] pio_pay, mon_pay;
  logic            pio_ack, mon_ack, sii_ncu_req;
  logic [31:0]     sii_ncu_data;
  logic [1:0]      sii_ncu_dparity;
  logic            gnt_tmo_err, spur_gnt_err;
`ifdef SII_NCU_PERR_INJ_EN
  logic            perr_inj;
`endif

  always #5 clk = ~clk;

  sii_ncu_xfer_sched #(.DATA_W(32), .PAY_BEATS(PB), .GNT_TMO(255)) dut (
    .iol2clk(clk), .rst(rst),
    .pio_vld(pio_vld), .pio_hdr(pio_hdr), .pio_pay(pio_pay), .pio_ack(pio_ack),
    .mon_vld(mon_vld), .mon_hdr(mon_hdr), .mon_pay(mon_pay), .mon_ack(mon_ack),
    .sii_ncu_req(sii_ncu_req), .ncu_sii_gnt(ncu_sii_gnt),
    .sii_ncu_data(sii_ncu_data), .sii_ncu_dparity(sii_ncu_dparity),
    .gnt_tmo_err(gnt_tmo_err), .spur_gnt_err(spur_gnt_err)
`ifdef SII_NCU_PERR_INJ_EN
    , .perr_inj(perr_inj)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  p;
    logic        pa;
    logic        ma;
  } beat_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [1:0] epar(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  // Requester side state
  bit               pend [2];
  logic [31:0]      hdr_v [2];
  logic [32*PB-1:0] pay_v [2];

  // Reference model state
  beat_t            q[$];
  bit               exp_req;
  bit               exp_tmo, exp_spur;
  int               wait_cnt;
  int               last_win;      // -1: no packet completed since reset
  int               cur_side;
  logic [31:0]      cur_hdr;
  logic [32*PB-1:0] cur_pay;
  bit               cur_arm;

  task automatic new_packet(input int s);
    pend[s]  = 1'b1;
    hdr_v[s] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    for (int k = 0; k < PB; k++) begin
      pay_v[s][32*k +: 32] = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_req  = 1'b0;
    exp_tmo  = 1'b0;
    exp_spur = 1'b0;
    wait_cnt = 0;
    last_win = -1;
    cur_arm  = 1'b0;
  endtask

  initial begin
    beat_t e;
    bit    was_tx;
    bit    r, g, grant_en, spur_en, busy_both;
    bit    inj;
    int    w;

    rst = 1'b1; ncu_sii_gnt = 1'b0;
    pio_vld = 1'b0; mon_vld = 1'b0;
    pio_hdr = 32'h0; mon_hdr = 32'h0; pio_pay = '0; mon_pay = '0;
`ifdef SII_NCU_PERR_INJ_EN
    perr_inj = 1'b0;
`endif
    pend[0] = 1'b0; pend[1] = 1'b0;
    model_reset();
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // ---- compare this cycle's outputs against the model
      if (q.size() > 0) begin
        e = q.pop_front();
        was_tx = 1'b1;
      end else begin
        e = '0;
        was_tx = 1'b0;
      end
      chk("data",     64'(sii_ncu_data),    64'(e.d));
      chk("dparity",  64'(sii_ncu_dparity), 64'(e.p));
      chk("pio_ack",  64'(pio_ack),         64'(e.pa));
      chk("mon_ack",  64'(mon_ack),         64'(e.ma));
      chk("req",      64'(sii_ncu_req),     64'(exp_req));
      chk("gnt_tmo",  64'(gnt_tmo_err),     64'(exp_tmo));
      chk("spur_gnt", 64'(spur_gnt_err),    64'(exp_spur));
      if (was_tx && (e.pa || e.ma)) begin
        last_win = cur_side;
        pend[cur_side] = 1'b0;
      end

      // ---- choose stimulus for this cycle
      busy_both = (cyc < 300);
      grant_en  = !(cyc >= 600 && cyc < 900);
      spur_en   = (cyc >= 1100);
      r = (cyc < 2) || (cyc == 1000) || (cyc == 1050) ||
          ((cyc >= 1800) && ($urandom_range(0, 49) == 0));
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && (busy_both || $urandom_range(0, 5) == 0)) new_packet(s);
      end
      if (exp_req) begin
        g = grant_en && ($urandom_range(0, 3) == 0);
      end else begin
        g = spur_en && ($urandom_range(0, 29) == 0);
      end
      if (r && $urandom_range(0, 1) == 1) g = 1'b1;
      inj = ($urandom_range(0, 2) == 0);

      rst = r; ncu_sii_gnt = g;
      pio_vld = pend[0]; pio_hdr = hdr_v[0]; pio_pay = pay_v[0];
      mon_vld = pend[1]; mon_hdr = hdr_v[1]; mon_pay = pay_v[1];
`ifdef SII_NCU_PERR_INJ_EN
      perr_inj = inj;
`else
      inj = 1'b0;
`endif

      // ---- advance the model by one cycle
      if (r) begin
        model_reset();
      end else begin
        if (g && !exp_req) exp_spur = 1'b1;
        if (exp_req) begin
          if (g) begin
            exp_req = 1'b0;
            q.push_back('{d: cur_hdr, p: epar(cur_hdr), pa: 1'b0, ma: 1'b0});
            for (int k = 0; k < PB; k++) begin
              e.d  = cur_pay[32*k +: 32];
              e.p  = epar(e.d) ^ ((k == 0 && cur_arm) ? 2'b01 : 2'b00);
              e.pa = (k == PB - 1) && (cur_side == 0);
              e.ma = (k == PB - 1) && (cur_side == 1);
              q.push_back(e);
            end
          end else begin
            wait_cnt++;
            if (wait_cnt >= 255) exp_tmo = 1'b1;
          end
        end else if (!was_tx && (pend[0] || pend[1])) begin
          if (pend[0] && pend[1]) w = (last_win < 0) ? 0 : (1 - last_win);
          else w = pend[1] ? 1 : 0;
          cur_side = w;
          cur_hdr  = hdr_v[w];
          cur_pay  = pay_v[w];
          cur_arm  = inj;
          exp_req  = 1'b1;
          wait_cnt = 0;
        end
      end

      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
